// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - program counter with next-PC priority and optional return-address stack (macro PC_RAS_EN)
module pc_ras #(
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned STEP       = 4,
  parameter int unsigned RAS_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic             jal,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             jr,
  input  logic [WIDTH-1:0] jr_target,
  output logic [WIDTH-1:0] pc_out,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf
);

  localparam logic [WIDTH-1:0] START_W = WIDTH'(START_ADDR);
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);

  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] seq_pc;

  // Sequential successor; also the return address a jal pushes.
  assign seq_pc = pc_out + STEP_W;

`ifdef PC_RAS_EN
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  // Circular storage: top points at the newest entry, so a push while full
  // naturally lands on the oldest slot.
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    top;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic             push;
  logic             pop;
  logic             empty_q;
  logic             full_q;
  logic             ovf_q;

  // Next-PC selection with RAS: jr > jal/jump > branch > sequential.
  always_comb begin
    pc_next  = seq_pc;
    push     = 1'b0;
    pop      = 1'b0;
    cnt_next = cnt;
    if (jr) begin
      if (cnt != '0) begin
        pop      = 1'b1;
        pc_next  = ras_mem[top];
        cnt_next = cnt - CW'(1);
      end else begin
        pc_next  = jr_target;
      end
    end else if (jal || jump) begin
      pc_next = jump_target;
      if (jal) begin
        push = 1'b1;
        if (cnt != DEPTH_C) cnt_next = cnt + CW'(1);
      end
    end else if (branch_taken) begin
      pc_next = branch_target;
    end
  end

  // Stack entries carry no reset; they are unreachable while cnt is zero.
  always_ff @(posedge clk) begin
    if (!reset && !stall && push) ras_mem[top + PW'(1)] <= seq_pc;
  end

  // Stack pointer, occupancy and status flags; stall freezes all of them.
  always_ff @(posedge clk) begin
    if (reset) begin
      top     <= '0;
      cnt     <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (!stall) begin
      if (push) begin
        top <= top + PW'(1);
        if (cnt == DEPTH_C) ovf_q <= 1'b1;
      end else if (pop) begin
        top <= top - PW'(1);
      end
      cnt     <= cnt_next;
      empty_q <= (cnt_next == '0);
      full_q  <= (cnt_next == DEPTH_C);
    end
  end

  assign ras_empty = empty_q;
  assign ras_full  = full_q;
  assign ras_ovf   = ovf_q;
`else
  // Next-PC selection without RAS: jr always uses jr_target, jal acts as jump.
  always_comb begin
    pc_next = seq_pc;
    if (jr)                  pc_next = jr_target;
    else if (jal || jump)    pc_next = jump_target;
    else if (branch_taken)   pc_next = branch_target;
  end

  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign ras_ovf   = 1'b0;
`endif

  // PC register: reset wins over stall, stall holds.
  always_ff @(posedge clk) begin
    if (reset)       pc_out <= START_W;
    else if (!stall) pc_out <= pc_next;
  end

endmodule

// File: tb/tb_pc_ras.sv
// tb/tb_pc_ras.sv - self-checking bench for pc_ras (queue model plus directed literals)
module tb_pc_ras;

`ifdef PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, jump, jal, jr;
  logic [31:0] branch_target, jump_target, jr_target;
  logic [31:0] pc_out;
  logic        ras_empty, ras_full, ras_ovf;

  logic        reset16;
  logic [15:0] pc16;
  logic        e16, f16, o16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_ras #(.START_ADDR(32'h100), .WIDTH(32), .STEP(4), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jal(jal), .jump_target(jump_target),
    .jr(jr), .jr_target(jr_target),
    .pc_out(pc_out), .ras_empty(ras_empty), .ras_full(ras_full), .ras_ovf(ras_ovf)
  );

  pc_ras #(.START_ADDR(16'hFFFC), .WIDTH(16), .STEP(4), .RAS_DEPTH(4)) dut16 (
    .clk(clk), .reset(reset16), .stall(1'b0),
    .branch_taken(1'b0), .branch_target(16'h0),
    .jump(1'b0), .jal(1'b0), .jump_target(16'h0),
    .jr(1'b0), .jr_target(16'h0),
    .pc_out(pc16), .ras_empty(e16), .ras_full(f16), .ras_ovf(o16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of return addresses, newest at the back.
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  logic        m_ovf;
  logic        m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_pc = 32'h100;
      m_q.delete();
      m_ovf = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid && !stall) begin
      if (jr) begin
        if (RAS_ON && m_q.size() > 0) m_pc = m_q.pop_back();
        else m_pc = jr_target;
      end else if (jal && RAS_ON) begin
        if (m_q.size() == DEPTH) begin
          void'(m_q.pop_front());
          m_ovf = 1'b1;
        end
        m_q.push_back(m_pc + 32'd4);
        m_pc = jump_target;
      end else if (jal || jump) begin
        m_pc = jump_target;
      end else if (branch_taken) begin
        m_pc = branch_target;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
  end

  // Every-cycle comparison against the model once it has seen reset.
  always @(negedge clk) begin
    if (m_valid) begin
      check("pc_model", pc_out, m_pc);
      check("empty_model", {31'b0, ras_empty}, {31'b0, (m_q.size() == 0)});
      check("full_model", {31'b0, ras_full}, {31'b0, (m_q.size() == DEPTH)});
      check("ovf_model", {31'b0, ras_ovf}, {31'b0, m_ovf});
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; branch_taken = 0; jump = 0; jal = 0; jr = 0;
  endtask

  initial begin
    reset = 1; reset16 = 1; idle();
    branch_target = 0; jump_target = 0; jr_target = 0;
    @(negedge clk); #1;
    tick();
    check("reset_pc", pc_out, 32'h100);
    check("reset_empty", {31'b0, ras_empty}, 32'd1);
    check("reset_full", {31'b0, ras_full}, 32'd0);
    check("reset_ovf", {31'b0, ras_ovf}, 32'd0);
    check("w16_reset", {16'b0, pc16}, 32'hFFFC);
    reset = 0; reset16 = 0;
    tick();
    check("seq1", pc_out, 32'h104);
    check("w16_wrap", {16'b0, pc16}, 32'h0000);
    tick(); check("seq2", pc_out, 32'h108);
    tick(); check("seq3", pc_out, 32'h10C);

    // Stall over a pending branch.
    jump = 1; jump_target = 32'h200; tick(); idle();
    check("jump_200", pc_out, 32'h200);
    branch_taken = 1; branch_target = 32'h400; stall = 1;
    tick(); check("stall1", pc_out, 32'h200);
    tick(); check("stall2", pc_out, 32'h200);
    stall = 0; tick(); idle();
    check("branch_400", pc_out, 32'h400);

    // jal / jr round trip.
    jump = 1; jump_target = 32'h10; tick(); idle();
    jal = 1; jump_target = 32'h80; tick(); idle();
    check("jal_80", pc_out, 32'h80);
    tick(); check("after_jal1", pc_out, 32'h84);
    tick(); check("after_jal2", pc_out, 32'h88);
    tick(); check("after_jal3", pc_out, 32'h8C);
    jr = 1; jr_target = 32'hDEAD; tick(); idle();
    check("jr_ret", pc_out, RAS_ON ? 32'h14 : 32'hDEAD);
    check("jr_empty", {31'b0, ras_empty}, 32'd1);

    // Overflow: five pushes into a four-deep stack, then five pops.
    jump = 1; jump_target = 32'h14; tick(); idle();
    for (int k = 1; k <= 5; k++) begin
      jal = 1; jump_target = 32'h1000 * k; tick();
      if (k == 4) check("full_after4", {31'b0, ras_full}, {31'b0, RAS_ON});
    end
    idle();
    check("ovf_set", {31'b0, ras_ovf}, {31'b0, RAS_ON});
    jr = 1; jr_target = 32'hBEEF;
    tick(); check("pop_E", pc_out, RAS_ON ? 32'h4004 : 32'hBEEF);
    tick(); check("pop_D", pc_out, RAS_ON ? 32'h3004 : 32'hBEEF);
    tick(); check("pop_C", pc_out, RAS_ON ? 32'h2004 : 32'hBEEF);
    tick(); check("pop_B", pc_out, RAS_ON ? 32'h1004 : 32'hBEEF);
    tick(); check("pop_empty", pc_out, 32'hBEEF);
    idle();
    check("ovf_sticky", {31'b0, ras_ovf}, {31'b0, RAS_ON});

    // jr beats jump and branch with an empty stack.
    jr = 1; jr_target = 32'h7770; jump = 1; jump_target = 32'h3333;
    branch_taken = 1; branch_target = 32'h5555;
    tick(); idle();
    check("jr_priority", pc_out, 32'h7770);

    // jr together with jal: pop only, no push.
    jal = 1; jump_target = 32'h600; tick(); idle();
    jr = 1; jal = 1; jr_target = 32'h40; jump_target = 32'h900; tick(); idle();
    check("jr_over_jal", pc_out, RAS_ON ? 32'h7774 : 32'h40);
    check("jr_over_jal_empty", {31'b0, ras_empty}, 32'd1);

    // Mid-sequence reset discards stacked entries.
    jal = 1; jump_target = 32'hA00; tick(); idle();
    reset = 1; stall = 1; tick(); idle(); reset = 0;
    check("mid_reset_pc", pc_out, 32'h100);
    check("mid_reset_empty", {31'b0, ras_empty}, 32'd1);
    check("mid_reset_ovf", {31'b0, ras_ovf}, 32'd0);
    tick(); check("post_reset", pc_out, 32'h104);
    jr = 1; jr_target = 32'h88; tick(); idle();
    check("post_reset_jr", pc_out, 32'h88);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
